// File: rtl/io_bus_slave_pkg.sv
// Shared types and constants for the register-mapped bus slave.
package io_bus_slave_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXEC    = 2'd1,
    ACK     = 2'd2,
    RELEASE = 2'd3
  } bus_slave_state_t;

  // global_constants
  localparam logic       BUS_READ          = 1'b1;
  localparam logic       BUS_WRITE         = 1'b0;
  localparam logic [7:0] DEFAULT_BASE_ADDR = 8'h10;

endpackage

// File: rtl/io_bus_slave_FSM.sv
// Four-phase handshake sequencer: owns the state register and decodes it
// into the enables used by the register datapath.
module io_bus_slave_FSM
  import io_bus_slave_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic handshake_1,
  input  logic hit,
  output logic accept,
  output logic exec_en,
  output logic ack_next,
  output logic busy
);

  bus_slave_state_t state;
  bus_slave_state_t state_next;
  logic             busy_r;

  // State register; busy is registered from the next state so it tracks state exactly
  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      busy_r <= 1'b0;
    end else begin
      state  <= state_next;
      busy_r <= (state_next != IDLE);
    end
  end

  // Next-state logic and enable decode
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    exec_en    = 1'b0;
    ack_next   = 1'b0;
    case (state)
      IDLE: begin
        if (handshake_1 && hit) begin
          state_next = EXEC;
          accept     = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      EXEC: begin
        state_next = ACK;
        exec_en    = 1'b1;
      end
      ACK: begin
        if (handshake_1) begin
          state_next = ACK;
        end else begin
          state_next = RELEASE;
        end
      end
      RELEASE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    ack_next = (state_next == ACK);
  end

  assign busy = busy_r;

endmodule

// File: rtl/io_bus_slave.sv
// Register-mapped bus slave: writable control registers plus read-only
// status registers behind a four-phase request/acknowledge handshake.
module io_bus_slave
  import io_bus_slave_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
  parameter int         NOS_REGS    = 8,
  parameter int         NOS_WR_REGS = 4
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic                                     bus_handshake_1,
  input  logic                                     bus_RW,
  input  logic [7:0]                               bus_reg_address,
  input  logic [31:0]                              bus_data_out,
  output logic [31:0]                              bus_data_in,
  output logic                                     bus_handshake_2,
  output logic [NOS_WR_REGS-1:0][31:0]             ctrl_regs,
  input  logic [NOS_REGS-NOS_WR_REGS-1:0][31:0]    status_regs,
  output logic [NOS_WR_REGS-1:0]                   wr_strobe,
  output logic                                     busy
);

  localparam int IDX_W = (NOS_REGS > 2) ? $clog2(NOS_REGS) : 1;

  logic [8:0]                  addr_ext;
  logic [8:0]                  lo_bound;
  logic [8:0]                  hi_bound;
  logic                        hit;
  logic [IDX_W-1:0]            index;

  logic                        accept;
  logic                        exec_en;
  logic                        ack_next;

  logic [IDX_W-1:0]            lat_idx;
  logic                        lat_rw;
  word_t                       lat_data;

  logic [NOS_WR_REGS-1:0][31:0] ctrl_r;
  logic [NOS_WR_REGS-1:0]      wr_hit_vec;
  logic [NOS_WR_REGS-1:0]      wr_strobe_r;
  word_t                       sel_word;
  word_t                       rd_reg;
  word_t                       data_in_r;
  logic                        hs2_r;

  // Nine-bit compare keeps a window near 8'hFF from wrapping back to zero
  assign addr_ext = {1'b0, bus_reg_address};
  assign lo_bound = {1'b0, BASE_ADDR};
  assign hi_bound = lo_bound + 9'(NOS_REGS);
  assign hit      = (addr_ext >= lo_bound) && (addr_ext < hi_bound);
  assign index    = IDX_W'(bus_reg_address - BASE_ADDR);

  io_bus_slave_FSM u_fsm (
    .clk         (clk),
    .reset       (reset),
    .handshake_1 (bus_handshake_1),
    .hit         (hit),
    .accept      (accept),
    .exec_en     (exec_en),
    .ack_next    (ack_next),
    .busy        (busy)
  );

  // Capture the request once at acceptance; later bus changes are ignored
  always_ff @(posedge clk) begin
    if (!reset) begin
      lat_idx  <= '0;
      lat_rw   <= BUS_WRITE;
      lat_data <= 32'h0000_0000;
    end else if (accept) begin
      lat_idx  <= index;
      lat_rw   <= bus_RW;
      lat_data <= bus_data_out;
    end else begin
      lat_idx  <= lat_idx;
      lat_rw   <= lat_rw;
      lat_data <= lat_data;
    end
  end

  // Write decode (read-only indices never match) and read-source mux
  always_comb begin
    wr_hit_vec = '0;
    sel_word   = 32'h0000_0000;
    for (int i = 0; i < NOS_WR_REGS; i++) begin
      wr_hit_vec[i] = exec_en && (lat_rw == BUS_WRITE) && (lat_idx == IDX_W'(i));
      sel_word      = (lat_idx == IDX_W'(i)) ? ctrl_r[i] : sel_word;
    end
    for (int i = 0; i < NOS_REGS - NOS_WR_REGS; i++) begin
      sel_word = (lat_idx == IDX_W'(i + NOS_WR_REGS)) ? status_regs[i] : sel_word;
    end
  end

  // Register file update, write strobe and read capture during EXEC
  always_ff @(posedge clk) begin
    if (!reset) begin
      ctrl_r      <= '0;
      wr_strobe_r <= '0;
      rd_reg      <= 32'h0000_0000;
    end else begin
      wr_strobe_r <= wr_hit_vec;
      for (int i = 0; i < NOS_WR_REGS; i++) begin
        ctrl_r[i] <= wr_hit_vec[i] ? lat_data : ctrl_r[i];
      end
      rd_reg <= (exec_en && (lat_rw == BUS_READ)) ? sel_word : rd_reg;
    end
  end

  // Bus outputs are registered from the next state so they are clean for OR-combining
  always_ff @(posedge clk) begin
    if (!reset) begin
      hs2_r     <= 1'b0;
      data_in_r <= 32'h0000_0000;
    end else begin
      hs2_r <= ack_next;
      if (ack_next && (lat_rw == BUS_READ)) begin
        data_in_r <= exec_en ? sel_word : rd_reg;
      end else begin
        data_in_r <= 32'h0000_0000;
      end
    end
  end

  assign ctrl_regs       = ctrl_r;
  assign wr_strobe       = wr_strobe_r;
  assign bus_handshake_2 = hs2_r;
  assign bus_data_in     = data_in_r;

endmodule

// File: tb/tb_io_bus_slave.sv
// Self-checking bench for io_bus_slave: table of transactions with a
// scoreboard queue, plus hand-written latency, reset and back-to-back cases.
module tb_io_bus_slave;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              hs1 = 1'b0;
  logic              rw = 1'b0;
  logic [7:0]        addr = 8'h00;
  logic [31:0]       wdata = 32'h0;
  logic [31:0]       data_in;
  logic              hs2;
  logic [3:0][31:0]  ctrl_regs;
  logic [3:0][31:0]  status_regs;
  logic [3:0]        wr_strobe;
  logic              busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [31:0] model_ctrl [4];

  typedef struct {
    logic [7:0]  addr;
    logic        rw;
    logic [31:0] wdata;
    logic        exp_ack;
    logic [3:0]  exp_strobe;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [16];
  vec_t sb_q [$];

  io_bus_slave #(.BASE_ADDR(8'h10), .NOS_REGS(8), .NOS_WR_REGS(4)) dut (
    .clk             (clk),
    .reset           (reset),
    .bus_handshake_1 (hs1),
    .bus_RW          (rw),
    .bus_reg_address (addr),
    .bus_data_out    (wdata),
    .bus_data_in     (data_in),
    .bus_handshake_2 (hs2),
    .ctrl_regs       (ctrl_regs),
    .status_regs     (status_regs),
    .wr_strobe       (wr_strobe),
    .busy            (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic check_ctrl(input string nm);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s_ctrl%0d", nm, i), ctrl_regs[i], model_ctrl[i]);
    end
  endtask

  // Drives one four-phase transaction starting at a negedge; returns the cycle hs2 was first seen
  task automatic run_txn(input vec_t v, output int ack_cyc);
    vec_t e;
    int   n;
    logic seen;
    logic any_busy;
    sb_q.push_back(v);
    addr  = v.addr;
    rw    = v.rw;
    wdata = v.wdata;
    hs1   = 1'b1;
    seen = 1'b0;
    any_busy = 1'b0;
    n = 0;
    ack_cyc = -1;
    while (!seen && n < 8) begin
      @(negedge clk);
      n++;
      any_busy = any_busy | busy;
      seen = hs2;
    end
    e = sb_q.pop_front();
    if (e.exp_ack) begin
      check("ack_seen", 32'(seen), 32'd1);
      if (seen) begin
        ack_cyc = cyc;
        check("strobe_first_ack", 32'(wr_strobe), 32'(e.exp_strobe));
        check("rdata_ack1", data_in, e.exp_rdata);
        addr  = 8'h12;
        rw    = ~e.rw;
        wdata = 32'h0BAD_0BAD;
        @(negedge clk);
        check("hs2_ack2", 32'(hs2), 32'd1);
        check("strobe_ack2", 32'(wr_strobe), 32'd0);
        check("rdata_ack2", data_in, e.exp_rdata);
      end
      hs1 = 1'b0;
      @(negedge clk);
      check("hs2_release", 32'(hs2), 32'd0);
      check("rdata_release", data_in, 32'd0);
    end else begin
      check("no_ack", 32'(seen), 32'd0);
      check("no_busy", 32'(any_busy), 32'd0);
      hs1 = 1'b0;
      @(negedge clk);
    end
    for (int i = 0; i < 4; i++) begin
      if (e.exp_strobe[i]) model_ctrl[i] = e.wdata;
    end
    check_ctrl("txn");
  endtask

  initial begin
    int c1;
    int c2;
    int n;
    logic seen;

    vecs[0]  = '{8'h11, 1'b0, 32'hDEADBEEF, 1'b1, 4'b0010, 32'h0};
    vecs[1]  = '{8'h11, 1'b1, 32'h0,        1'b1, 4'b0000, 32'hDEADBEEF};
    vecs[2]  = '{8'h14, 1'b1, 32'h0,        1'b1, 4'b0000, 32'h12345678};
    vecs[3]  = '{8'h17, 1'b1, 32'h0,        1'b1, 4'b0000, 32'h55AA55AA};
    vecs[4]  = '{8'h10, 1'b0, 32'h01234567, 1'b1, 4'b0001, 32'h0};
    vecs[5]  = '{8'h13, 1'b0, 32'h89ABCDEF, 1'b1, 4'b1000, 32'h0};
    vecs[6]  = '{8'h10, 1'b1, 32'h0,        1'b1, 4'b0000, 32'h01234567};
    vecs[7]  = '{8'h15, 1'b0, 32'hFFFFFFFF, 1'b1, 4'b0000, 32'h0};
    vecs[8]  = '{8'h15, 1'b1, 32'h0,        1'b1, 4'b0000, 32'hCAFEF00D};
    vecs[9]  = '{8'h0F, 1'b0, 32'h11111111, 1'b0, 4'b0000, 32'h0};
    vecs[10] = '{8'h18, 1'b0, 32'h22222222, 1'b0, 4'b0000, 32'h0};
    vecs[11] = '{8'h13, 1'b1, 32'h0,        1'b1, 4'b0000, 32'h89ABCDEF};
    vecs[12] = '{8'h12, 1'b1, 32'h0,        1'b1, 4'b0000, 32'h0};
    vecs[13] = '{8'h16, 1'b1, 32'h0,        1'b1, 4'b0000, 32'h0BADF00D};
    vecs[14] = '{8'hFF, 1'b0, 32'h33333333, 1'b0, 4'b0000, 32'h0};
    vecs[15] = '{8'h0F, 1'b1, 32'h0,        1'b0, 4'b0000, 32'h0};

    status_regs[0] = 32'h12345678;
    status_regs[1] = 32'hCAFEF00D;
    status_regs[2] = 32'h0BADF00D;
    status_regs[3] = 32'h55AA55AA;
    for (int i = 0; i < 4; i++) model_ctrl[i] = 32'h0;

    // Reset state
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_hs2", 32'(hs2), 32'd0);
    check("rst_data", data_in, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_strobe", 32'(wr_strobe), 32'd0);
    check_ctrl("rst");
    reset = 1'b1;
    @(negedge clk);

    // Latency and read of first status register
    addr = 8'h14; rw = 1'b1; wdata = 32'h0; hs1 = 1'b1;
    @(negedge clk);
    check("lat_exec_hs2", 32'(hs2), 32'd0);
    check("lat_exec_busy", 32'(busy), 32'd1);
    @(negedge clk);
    @(negedge clk);
    check("lat_n2_hs2", 32'(hs2), 32'd1);
    check("lat_n2_data", data_in, 32'h12345678);
    hs1 = 1'b0;
    @(negedge clk);
    check("lat_drop_hs2", 32'(hs2), 32'd0);
    check("lat_drop_data", data_in, 32'd0);
    @(negedge clk);

    // Table-driven transactions
    for (int k = 0; k < 16; k++) begin
      run_txn(vecs[k], c1);
    end
    @(negedge clk);

    // Request dropped during EXEC: single-cycle ACK
    addr = 8'h12; rw = 1'b0; wdata = 32'h77777777; hs1 = 1'b1;
    @(negedge clk);
    hs1 = 1'b0;
    @(negedge clk);
    check("drop_ack_hs2", 32'(hs2), 32'd1);
    check("drop_ack_strobe", 32'(wr_strobe), 32'b0100);
    @(negedge clk);
    check("drop_rel_hs2", 32'(hs2), 32'd0);
    check("drop_rel_busy", 32'(busy), 32'd1);
    @(negedge clk);
    check("drop_idle_busy", 32'(busy), 32'd0);
    model_ctrl[2] = 32'h77777777;
    check_ctrl("drop");

    // Reset while a write is in EXEC
    addr = 8'h10; rw = 1'b0; wdata = 32'hA5A5A5A5; hs1 = 1'b1;
    @(negedge clk);
    check("rstx_busy", 32'(busy), 32'd1);
    reset = 1'b0;
    hs1 = 1'b0;
    @(negedge clk);
    check("rstx_hs2", 32'(hs2), 32'd0);
    check("rstx_busy_low", 32'(busy), 32'd0);
    check("rstx_strobe", 32'(wr_strobe), 32'd0);
    for (int i = 0; i < 4; i++) model_ctrl[i] = 32'h0;
    check_ctrl("rstx");
    reset = 1'b1;
    @(negedge clk);
    check("rstx_after_hs2", 32'(hs2), 32'd0);
    check_ctrl("rstx_after");

    // Back-to-back writes, second raised as soon as hs2 falls
    run_txn('{8'h10, 1'b0, 32'hAAAA0001, 1'b1, 4'b0001, 32'h0}, c1);
    run_txn('{8'h11, 1'b0, 32'hAAAA0002, 1'b1, 4'b0010, 32'h0}, c2);
    check("b2b_spacing", 32'((c1 >= 0) && (c2 - c1 >= 4)), 32'd1);

    // Request held in a non-owned address never becomes busy
    addr = 8'h18; rw = 1'b1; hs1 = 1'b1;
    seen = 1'b0;
    n = 0;
    while (n < 6) begin
      @(negedge clk);
      n++;
      seen = seen | hs2 | busy;
    end
    hs1 = 1'b0;
    check("miss_hold", 32'(seen), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
